// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter (8N1/8N2, optional parity) fed by a small byte FIFO.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_div_i            clocks per bit minus 1 (sampled at frame start)
//   cfg_stop2_i          1 = two stop bits (sampled at frame start)
//   cfg_parity_en_i      parity enable     (only with UART_TX_PARITY_EN)
//   cfg_parity_odd_i     1 = odd parity    (only with UART_TX_PARITY_EN)
//   tx_valid_i/tx_data_i push request and byte
//   tx_ready_o           FIFO not full
//   fifo_count_o         FIFO occupancy
//   busy_o               frame in progress or FIFO non-empty (registered)
//   uart_tx_o            serial line, idle high (registered)
// Optional feature macro: UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    input  logic                          cfg_stop2_i,
`ifdef UART_TX_PARITY_EN
    input  logic                          cfg_parity_en_i,
    input  logic                          cfg_parity_odd_i,
`endif
    input  logic                          tx_valid_i,
    input  logic [7:0]                    tx_data_i,
    output logic                          tx_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o,
    output logic                          uart_tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e               state_q, state_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic [DIV_WIDTH-1:0] baud_q, baud_d, div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 stop2_q, stop2_d, par_en_q, par_en_d, par_q, par_d;
    logic                 tx_q, tx_d, busy_q;
    logic                 push, pop, bit_end, par_en_w, par_odd_w;

`ifdef UART_TX_PARITY_EN
    assign par_en_w  = cfg_parity_en_i;
    assign par_odd_w = cfg_parity_odd_i;
`else
    assign par_en_w  = 1'b0;
    assign par_odd_w = 1'b0;
`endif

    assign tx_ready_o   = count_q != CNT_FULL;
    assign fifo_count_o = count_q;
    assign busy_o       = busy_q;
    assign uart_tx_o    = tx_q;

    always_comb begin
        push     = tx_valid_i & tx_ready_o;
        bit_end  = baud_q == div_q;
        pop      = 1'b0;
        state_d  = state_q;
        baud_d   = (state_q == IDLE || bit_end) ? '0 : baud_q + DIV_WIDTH'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        div_d    = div_q;
        stop2_d  = stop2_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        case (state_q)
            IDLE:   pop = count_q != '0;
            START:  if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                // bit_q wraps 7 -> 0, leaving it cleared for the stop-bit count
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: if (bit_end) begin
                if (bit_q[0] == stop2_q) begin
                    state_d = IDLE;
                    bit_d   = '0;
                    pop     = count_q != '0;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            default: ;
        endcase
        // Frame start: pop the head byte and latch the frame's configuration
        if (pop) begin
            state_d  = START;
            shift_d  = mem_q[rd_ptr_q];
            div_d    = cfg_div_i;
            stop2_d  = cfg_stop2_i;
            par_en_d = par_en_w;
            par_d    = ^mem_q[rd_ptr_q] ^ par_odd_w;
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        // Line level is registered from the next state so it changes on the entry edge
        tx_d = state_d == START  ? 1'b0 :
               state_d == DATA   ? shift_d[0] :
               state_d == PARITY ? par_d : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            stop2_q  <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            baud_q   <= baud_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            stop2_q  <= stop2_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= (state_q != IDLE) | (count_q != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_i;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_div = 16'd3;
    logic        cfg_stop2 = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready, busy, uart_tx;
    logic [2:0]  fifo_count;
`ifdef UART_TX_PARITY_EN
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
`endif
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_div_i        (cfg_div),
        .cfg_stop2_i      (cfg_stop2),
`ifdef UART_TX_PARITY_EN
        .cfg_parity_en_i  (cfg_parity_en),
        .cfg_parity_odd_i (cfg_parity_odd),
`endif
        .tx_valid_i       (tx_valid),
        .tx_data_i        (tx_data),
        .tx_ready_o       (tx_ready),
        .fifo_count_o     (fifo_count),
        .busy_o           (busy),
        .uart_tx_o        (uart_tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the line from sample `first` of a frame (one sample per negedge) to its end.
    // par < 0 means no parity bit.
    task automatic expect_frame(input string tag, input logic [7:0] b, input int div,
                                input int nstop, input int par, input int first);
        int nbits;
        nbits = 9 + (par >= 0 ? 1 : 0) + nstop;
        for (int s = first; s < nbits * (div + 1); s++) begin
            int k;
            logic e;
            k = s / (div + 1);
            e = k == 0 ? 1'b0 : k < 9 ? b[k-1] : (par >= 0 && k == 9) ? par[0] : 1'b1;
            check($sformatf("%s_s%0d", tag, s), uart_tx, e);
            @(negedge clk);
        end
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_%0d", tag, i), uart_tx, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55 at div=3, one stop bit: 40-clock frame
        tx_valid = 1'b1; tx_data = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
        check("t1_count_push", fifo_count, 1);
        check("t1_busy_pre", busy, 0);
        check("t1_tx_pre", uart_tx, 1);
        @(negedge clk);
        check("t1_count_pop", fifo_count, 0);
        check("t1_busy", busy, 1);
        expect_frame("t1", 8'h55, 3, 1, -1, 0);
        check("t1_busy_end", busy, 1);
        check("t1_count_end", fifo_count, 0);
        @(negedge clk);
        check("t1_busy_fall", busy, 0);
        idle_cycles("t1_idle", 4);

        // Back-to-back 0x00, 0xFF at div=0
        cfg_div = 16'd0;
        tx_valid = 1'b1; tx_data = 8'h00;
        @(negedge clk);
        tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        check("t2_count", fifo_count, 1);
        expect_frame("t2a", 8'h00, 0, 1, -1, 0);
        expect_frame("t2b", 8'hFF, 0, 1, -1, 0);
        check("t2_count_end", fifo_count, 0);
        idle_cycles("t2_idle", 4);

        // Five bytes at div=7, filling the FIFO while frame 1 runs
        cfg_div = 16'd7;
        tx_valid = 1'b1; tx_data = 8'h01;
        @(negedge clk);
        tx_valid = 1'b0;
        check("t3_cnt_a", fifo_count, 1);
        @(negedge clk);
        check("t3_cnt_b", fifo_count, 0);
        tx_valid = 1'b1; tx_data = 8'h02;
        @(negedge clk);
        check("t3_cnt_c", fifo_count, 1);
        tx_data = 8'h03;
        @(negedge clk);
        check("t3_cnt_d", fifo_count, 2);
        tx_data = 8'h04;
        @(negedge clk);
        check("t3_cnt_e", fifo_count, 3);
        check("t3_ready_3", tx_ready, 1);
        tx_data = 8'h05;
        @(negedge clk);
        check("t3_cnt_f", fifo_count, 4);
        check("t3_ready_full", tx_ready, 0);
        tx_data = 8'h99;
        @(negedge clk);
        tx_valid = 1'b0;
        check("t3_cnt_drop", fifo_count, 4);
        check("t3_ready_full2", tx_ready, 0);
        expect_frame("t3_b1", 8'h01, 7, 1, -1, 5);
        check("t3_cnt_after1", fifo_count, 3);
        check("t3_ready_after1", tx_ready, 1);
        expect_frame("t3_b2", 8'h02, 7, 1, -1, 0);
        expect_frame("t3_b3", 8'h03, 7, 1, -1, 0);
        expect_frame("t3_b4", 8'h04, 7, 1, -1, 0);
        expect_frame("t3_b5", 8'h05, 7, 1, -1, 0);
        check("t3_cnt_end", fifo_count, 0);
        idle_cycles("t3_idle", 20);
        check("t3_busy_end", busy, 0);

        // Two stop bits, div change mid-frame applies only to the next frame
        cfg_div = 16'd1; cfg_stop2 = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h3C;
        @(negedge clk);
        tx_data = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0;
        cfg_div = 16'd5;
        check("t4_count", fifo_count, 1);
        expect_frame("t4a", 8'h3C, 1, 2, -1, 0);
        expect_frame("t4b", 8'hC3, 5, 2, -1, 0);
        idle_cycles("t4_idle", 4);
        cfg_stop2 = 1'b0;

        // Asynchronous reset mid-DATA of 0xA5 with two bytes queued
        cfg_div = 16'd3;
        tx_valid = 1'b1; tx_data = 8'hA5;
        @(negedge clk);
        tx_data = 8'h11;
        @(negedge clk);
        tx_data = 8'h22;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_tx_mid", uart_tx, 0);
        check("t5_count_mid", fifo_count, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_tx", uart_tx, 1);
        check("t5_rst_count", fifo_count, 0);
        check("t5_rst_ready", tx_ready, 1);
        check("t5_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles("t5_idle", 60);
        check("t5_count_end", fifo_count, 0);
        check("t5_busy_end", busy, 0);

`ifdef UART_TX_PARITY_EN
        // Even then odd parity on 0x07 (three ones)
        cfg_div = 16'd1; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h07;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        expect_frame("t6_even", 8'h07, 1, 1, 1, 0);
        idle_cycles("t6_idle_a", 4);
        cfg_parity_odd = 1'b1;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        expect_frame("t6_odd", 8'h07, 1, 1, 0, 0);
        idle_cycles("t6_idle_b", 4);
        cfg_parity_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
